// File: rtl/keypad_emulator.sv
//------------------------------------------------------------------------------
// keypad_emulator
// Emulates one key of a 4x4 matrix keypad, with contact bounce, in front of a
// column-scanning keypad controller.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keypad_emulator #(
  parameter int BOUNCE_CYCLES  = 2,
  parameter int BOUNCE_TOGGLES = 1,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done
);

  localparam int BC_W  = $clog2(BOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (BC_W > 16) ? ((BC_W > GAP_W) ? BC_W : GAP_W)
                                     : ((GAP_W > 16) ? GAP_W : 16);
  localparam int PH_W  = $clog2(2 * BOUNCE_TOGGLES + 1) + 1;

  localparam logic [CNT_W-1:0] BC_LAST  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST  =
    PH_W'((BOUNCE_TOGGLES > 0) ? (2 * BOUNCE_TOGGLES - 1) : 0);
  localparam bit BOUNCE_EN = (BOUNCE_TOGGLES > 0);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  state_t           state_q,   state_d;
  logic             contact_q, contact_d;
  logic             done_q,    done_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [PH_W-1:0]  ph_q,      ph_d;
  logic [3:0]       key_q,     key_d;
  logic [15:0]      hold_q,    hold_d;

  logic [CNT_W-1:0] hold_last;
  logic [1:0]       key_col;
  logic [1:0]       key_row;
  logic             accept;

  // A zero hold request is stretched to a single cycle.
  assign hold_last = (hold_q == 16'd0) ? '0 : CNT_W'(hold_q - 16'd1);
  assign accept    = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    key_d     = key_q;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        contact_d = 1'b0;
        if (accept) begin
          key_d     = cmd_key;
          hold_d    = cmd_hold;
          cnt_d     = '0;
          ph_d      = '0;
          contact_d = 1'b1;
          state_d   = BOUNCE_EN ? ST_BOUNCE_IN : ST_HOLD;
        end
      end

      ST_BOUNCE_IN: begin
        if (cnt_q == BC_LAST) begin
          cnt_d = '0;
          if (ph_q == PH_LAST) begin
            ph_d      = '0;
            contact_d = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            ph_d      = ph_q + 1'b1;
            contact_d = ~contact_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d     = '0;
          ph_d      = '0;
          contact_d = 1'b0;
          state_d   = BOUNCE_EN ? ST_BOUNCE_OUT : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BOUNCE_OUT: begin
        if (cnt_q == BC_LAST) begin
          cnt_d = '0;
          if (ph_q == PH_LAST) begin
            ph_d      = '0;
            contact_d = 1'b0;
            state_d   = ST_GAP;
          end else begin
            ph_d      = ph_q + 1'b1;
            contact_d = ~contact_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        contact_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        contact_d = 1'b0;
        cnt_d     = '0;
        ph_d      = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      ph_q      <= '0;
      key_q     <= 4'd0;
      hold_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
    end
  end

  // Matrix position of the latched key: {column, row}.
  always_comb begin
    key_col = 2'd0;
    key_row = 2'd0;
    case (key_q)
      4'hA: begin key_col = 2'd0; key_row = 2'd0; end
      4'h7: begin key_col = 2'd0; key_row = 2'd1; end
      4'h4: begin key_col = 2'd0; key_row = 2'd2; end
      4'h1: begin key_col = 2'd0; key_row = 2'd3; end
      4'h0: begin key_col = 2'd1; key_row = 2'd0; end
      4'h8: begin key_col = 2'd1; key_row = 2'd1; end
      4'h5: begin key_col = 2'd1; key_row = 2'd2; end
      4'h2: begin key_col = 2'd1; key_row = 2'd3; end
      4'hB: begin key_col = 2'd2; key_row = 2'd0; end
      4'h9: begin key_col = 2'd2; key_row = 2'd1; end
      4'h6: begin key_col = 2'd2; key_row = 2'd2; end
      4'h3: begin key_col = 2'd2; key_row = 2'd3; end
      4'hF: begin key_col = 2'd3; key_row = 2'd0; end
      4'hE: begin key_col = 2'd3; key_row = 2'd1; end
      4'hD: begin key_col = 2'd3; key_row = 2'd2; end
      4'hC: begin key_col = 2'd3; key_row = 2'd3; end
      default: begin key_col = 2'd0; key_row = 2'd0; end
    endcase
  end

  assign row       = (contact_q && col[key_col]) ? (4'b0001 << key_row) : 4'b0000;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
//------------------------------------------------------------------------------
// tb_keypad_emulator
// Self-checking bench: instance a uses default bounce, instance b has none.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_emulator;

  localparam int BC  = 2;
  localparam int BT  = 1;
  localparam int GP  = 4;
  localparam int GP0 = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_key = 4'd0, b_key = 4'd0;
  logic [15:0] a_hold = 16'd0, b_hold = 16'd0;
  logic [3:0]  a_col = 4'd0, b_col = 4'd0;
  logic        a_ready, b_ready, a_busy, b_busy, a_done, b_done;
  logic [3:0]  a_row, b_row;

  int checks = 0;
  int errors = 0;

  // keymap[column][row] as printed on the keypad
  int keymap [4][4] = '{'{10, 7, 4, 1}, '{0, 8, 5, 2}, '{11, 9, 6, 3}, '{15, 14, 13, 12}};

  keypad_emulator dut_a (
    .clk(clk), .nrst(nrst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_key(a_key), .cmd_hold(a_hold), .col(a_col), .row(a_row),
    .busy(a_busy), .done(a_done)
  );

  keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_TOGGLES(0), .GAP_CYCLES(GP0)) dut_b (
    .clk(clk), .nrst(nrst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_key(b_key), .cmd_hold(b_hold), .col(b_col), .row(b_row),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  function automatic int pos_col(input int key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keymap[c][r] == key) return c;
    return 0;
  endfunction

  function automatic int pos_row(input int key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keymap[c][r] == key) return r;
    return 0;
  endfunction

  // Contact level k cycles after acceptance, from the event timeline.
  function automatic bit model_contact(input int k, input int bt, input int hold);
    int h, lin;
    h   = (hold == 0) ? 1 : hold;
    lin = 2 * bt * BC;
    if (k < 1) return 1'b0;
    if (k <= lin) return (((k - 1) / BC) % 2) == 0;
    if (k <= lin + h) return 1'b1;
    if (k <= 2 * lin + h) return (((k - lin - h - 1) / BC) % 2) == 1;
    return 1'b0;
  endfunction

  // Called inside cycle 0 (after a posedge); leaves the bench in the done cycle.
  task automatic run_event(input int u, input int key, input int hold, input int mode,
                           input logic [3:0] fixed, input bit keep);
    int bt, gp, total, kc, kr;
    logic [3:0] c, exp_row, o_row;
    logic o_ready, o_busy, o_done;
    bt    = (u == 0) ? BT : 0;
    gp    = (u == 0) ? GP : GP0;
    total = 4 * bt * BC + ((hold == 0) ? 1 : hold) + gp;
    kc    = pos_col(key);
    kr    = pos_row(key);
    if (u == 0) begin a_valid = 1'b1; a_key = 4'(key); a_hold = 16'(hold); end
    else        begin b_valid = 1'b1; b_key = 4'(key); b_hold = 16'(hold); end
    #1;
    o_ready = (u == 0) ? a_ready : b_ready;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready u=%0d key=%0h got=%b exp=1", u, key, o_ready);
    end
    for (int k = 1; k <= total + 1; k++) begin
      @(posedge clk);
      #1;
      c = (mode == 0) ? 4'($urandom) : (mode == 1) ? fixed : 4'(1 << (k % 4));
      if (u == 0) begin
        a_col = c;
        if (k == 1 && !keep) a_valid = 1'b0;
        if (k <= total) begin a_key = 4'($urandom); a_hold = 16'($urandom); end
      end else begin
        b_col = c;
        if (k == 1 && !keep) b_valid = 1'b0;
        if (k <= total) begin b_key = 4'($urandom); b_hold = 16'($urandom); end
      end
      #1;
      o_row   = (u == 0) ? a_row   : b_row;
      o_busy  = (u == 0) ? a_busy  : b_busy;
      o_ready = (u == 0) ? a_ready : b_ready;
      o_done  = (u == 0) ? a_done  : b_done;
      exp_row = (model_contact(k, bt, hold) && c[kc]) ? 4'(1 << kr) : 4'b0000;
      checks++;
      if (o_row !== exp_row) begin
        errors++;
        $display("FAIL row u=%0d key=%0h hold=%0d k=%0d col=%b got=%b exp=%b",
                 u, key, hold, k, c, o_row, exp_row);
      end
      checks++;
      if (o_busy !== (k <= total) || o_ready !== (k == total + 1) || o_done !== (k == total + 1)) begin
        errors++;
        $display("FAIL status u=%0d key=%0h hold=%0d k=%0d busy/ready/done got=%b%b%b exp=%b%b%b",
                 u, key, hold, k, o_busy, o_ready, o_done, k <= total, k == total + 1, k == total + 1);
      end
      if (u == 1 && mode == 2 && o_row != 4'b0000) begin
        for (int ci = 0; ci < 4; ci++)
          for (int ri = 0; ri < 4; ri++)
            if (c[ci] && o_row[ri]) begin
              checks++;
              if (keymap[ci][ri] != key) begin
                errors++;
                $display("FAIL decode got=%0h exp=%0h", keymap[ci][ri], key);
              end
            end
      end
    end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    a_col = 4'b1111;
    b_col = 4'b1111;
    #1;
    checks++;
    if ({a_row, a_busy, a_done, a_ready} !== 7'b0000_001) begin
      errors++;
      $display("FAIL reset_a row/busy/done/ready got=%b exp=0000001", {a_row, a_busy, a_done, a_ready});
    end
    checks++;
    if ({b_row, b_busy, b_done, b_ready} !== 7'b0000_001) begin
      errors++;
      $display("FAIL reset_b row/busy/done/ready got=%b exp=0000001", {b_row, b_busy, b_done, b_ready});
    end
    nrst = 1'b1;
    idle(2);
  endtask

  task automatic test_directed();
    run_event(0, 5, 3, 1, 4'b0010, 1'b0);
    idle(2);
    run_event(0, $urandom_range(0, 15), 4, 1, 4'b0000, 1'b0);
    idle(1);
    run_event(0, 13, 5, 1, 4'b1111, 1'b0);
    idle(1);
    run_event(1, 13, 3, 1, 4'b1111, 1'b0);
    idle(1);
  endtask

  task automatic test_hold_zero();
    run_event(0, $urandom_range(0, 15), 0, 0, 4'b0000, 1'b0);
    idle(1);
    run_event(1, $urandom_range(0, 15), 0, 1, 4'b1111, 1'b0);
    idle(1);
  endtask

  task automatic test_all_keys();
    for (int key = 0; key < 16; key++) begin
      run_event(1, key, $urandom_range(4, 6), 2, 4'b0000, 1'b0);
      idle(1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_event($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 8), 0, 4'b0000, 1'b0);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    run_event(0, $urandom_range(0, 15), $urandom_range(1, 5), 0, 4'b0000, 1'b1);
    run_event(0, $urandom_range(0, 15), $urandom_range(0, 5), 0, 4'b0000, 1'b1);
    run_event(0, $urandom_range(0, 15), $urandom_range(1, 5), 0, 4'b0000, 1'b0);
    idle(1);
    run_event(1, $urandom_range(0, 15), $urandom_range(1, 5), 0, 4'b0000, 1'b1);
    run_event(1, $urandom_range(0, 15), $urandom_range(1, 5), 0, 4'b0000, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_abort();
    int seen_done;
    a_valid = 1'b1;
    a_key   = 4'h5;
    a_hold  = 16'd5;
    a_col   = 4'b0010;
    @(posedge clk);
    #2;
    a_valid = 1'b0;
    // cycles 1-4 are bounce-in, so cycle 6 is inside HOLD
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (a_row !== 4'b0100 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre row/busy got=%b/%b exp=0100/1", a_row, a_busy);
    end
    nrst = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if ({a_row, a_busy, a_ready, a_done} !== 7'b0000_010) begin
      errors++;
      $display("FAIL abort row/busy/ready/done got=%b exp=0000010", {a_row, a_busy, a_ready, a_done});
    end
    nrst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (a_done !== 1'b0 || a_busy !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d cycles with done/busy exp=0", seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_zero();
    test_all_keys();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, 2, cycles per contact-bounce phase (>=1).
REQ-002 Parameter BOUNCE_TOGGLES, 1, high/low bounce pairs at press and at release (0 = no bounce).
REQ-003 Parameter GAP_CYCLES, 4, forced-release cycles after each key event (>=1).
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 nrst  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  key-event request.
REQ-007 cmd_ready  output  1  emulator can accept a request.
REQ-008 cmd_key  input  4  hex key code to press.
REQ-009 cmd_hold  input  16  stable-contact duration in cycles.
REQ-010 col  input  4  column drive from the scanner, active-high, normally one-hot.
REQ-011 row  output  4  row sense back to the scanner, active-high.
REQ-012 busy  output  1  key event in progress.
REQ-013 done  output  1  one-cycle pulse at event completion.

Function
REQ-014 The key map SHALL be: col0 rows0-3 = A,7,4,1; col1 = 0,8,5,2; col2 = B,9,6,3; col3 = F,E,D,C.
REQ-015 A request SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; on acceptance cmd_key and cmd_hold SHALL be latched internally.
REQ-016 cmd_ready SHALL be high only in IDLE; cmd_valid outside IDLE SHALL be ignored, with no queuing.
REQ-017 busy SHALL be high in every state except IDLE.
REQ-018 States SHALL be IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT and GAP, with an internal registered contact bit.
REQ-019 IDLE: contact=0. Acceptance SHALL move to BOUNCE_IN, or to HOLD if BOUNCE_TOGGLES=0.
REQ-020 BOUNCE_IN SHALL run 2*BOUNCE_TOGGLES phases of BOUNCE_CYCLES each, with contact alternating high,low,... starting high, then go to HOLD.
REQ-021 HOLD SHALL hold contact=1 for max(cmd_hold,1) cycles, then go to BOUNCE_OUT, or to GAP if BOUNCE_TOGGLES=0.
REQ-022 BOUNCE_OUT SHALL run 2*BOUNCE_TOGGLES phases of BOUNCE_CYCLES each, with contact alternating low,high,... starting low, then go to GAP.
REQ-023 GAP SHALL hold contact=0 for GAP_CYCLES cycles, then go to IDLE.
REQ-024 done SHALL be high for exactly the first IDLE cycle after GAP; cmd_ready SHALL also be high on that cycle, so back-to-back acceptance is allowed.
REQ-025 row SHALL be combinational from col and registered state: row = one-hot(key row) when contact=1 and col bit (key column) = 1, else 4'b0000.
REQ-026 Extra col bits set alongside the key column SHALL NOT suppress row; col=0 SHALL give row=0.
REQ-027 Phase and hold counters SHALL be wide enough for 16-bit cmd_hold and SHALL NOT wrap before the terminal count.
REQ-028 Timing: acceptance at cycle T puts the first contact=1 at cycle T+1.
REQ-029 Total event length from T+1 to done SHALL be 4*BOUNCE_TOGGLES*BOUNCE_CYCLES + max(cmd_hold,1) + GAP_CYCLES cycles, with done on the cycle after.

Reset
REQ-030 When nrst=0 at a posedge the block SHALL enter IDLE, clear contact and counters, and leave the latched key at 0.
REQ-031 Post-reset outputs SHALL be: row=0, busy=0, done=0, cmd_ready=1.
REQ-032 Reset during any state SHALL abort the event with no done pulse.

Verification
REQ-033 Defaults, key=5, hold=3, col held at 0010, accept at cycle 0 -> row=0100 on cycles 1-2, 0 on 3-4, 0100 on 5-7, 0 on 8-9, 0100 on 10-11, 0 on 12-15; done=1 and cmd_ready=1 at cycle 16.
REQ-034 All 16 keys, BOUNCE_TOGGLES=0, scanner rotating col 0001->0010->0100->1000 every cycle -> row equals the mapped one-hot only when the key column is driven; the decoded key matches cmd_key.
REQ-035 hold=0 -> HOLD lasts exactly 1 cycle.
REQ-036 cmd_valid held high through an event -> second request accepted exactly at the done cycle; no request accepted while busy.
REQ-037 nrst=0 asserted during HOLD -> next cycle row=0, busy=0, cmd_ready=1, and no done pulse.
REQ-038 col=0000 for a whole event, or col=1111 with key=D -> row=0 throughout, or row=0100 whenever contact=1, respectively.
